dimm_cmd_frontend: RTL and testbench

- Multi-rank DDR4 command front end for the DIMM emulation top. Replaces the single-rank decode and the fixed tristate enables.
- Decodes the command/address bus per rank and tracks the open row of every rank/bank.
- Schedules read and write data bursts through a latency pipeline, and emits per-beat dq/dqs drive and capture strobes plus the rank/bank/row/column of each beat for the Chip array.

---
 rtl/dimm_cmd_frontend.sv | 225 ++++++++++++++++++++++
 tb/tb_dimm_cmd_frontend.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dimm_cmd_frontend.sv
// Multi-rank DDR4 command front end: CA decode, per-bank open-row tracking, burst scheduler.
// Latency: row_open/cmd_err one cycle after the command edge; first beat RL (read) / WL (write) cycles after it.
// Backpressure: none, because the CA bus cannot stall. Illegal or colliding commands are dropped and pulse cmd_err.
//
// Ports:
//   clk, reset (async, active high), cke, cs_n[RANKS], act_n, A, bg, ba, parity : CA bus inputs
//   row_open[RANKS*NB]   : open flag per rank/bank, index = rank*NB + bg*2^BAWIDTH + ba
//   rd_drive, wr_capture : dq/dqs drive enable during read beats, capture strobe during write beats
//   beat_rank/bg/ba/row/col, beat_last : address of the current beat; hold their value between bursts
//   cmd_err              : one-cycle pulse for an illegal or dropped command
//   alert_n              : CA parity alert, active low
// Optional feature: define DIMM_CA_PARITY_EN to check even CA parity over {act_n, A, bg, ba}.
module dimm_cmd_frontend #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int RL        = 22,
  parameter int WL        = 16,
  localparam int NB  = 2 ** (BGWIDTH + BAWIDTH),
  localparam int TB  = RANKS * NB,
  localparam int RKW = (RANKS > 1) ? $clog2(RANKS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [RANKS-1:0]     cs_n,
  input  logic                 act_n,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic                 parity,
  output logic [TB-1:0]        row_open,
  output logic                 rd_drive,
  output logic                 wr_capture,
  output logic [RKW-1:0]       beat_rank,
  output logic [BGWIDTH-1:0]   beat_bg,
  output logic [BAWIDTH-1:0]   beat_ba,
  output logic [ADDRWIDTH-1:0] beat_row,
  output logic [COLWIDTH-1:0]  beat_col,
  output logic                 beat_last,
  output logic                 cmd_err,
  output logic                 alert_n
);
  localparam int TBW   = (TB > 1) ? $clog2(TB) : 1;
  localparam int BLW   = $clog2(BL);
  localparam int DEPTH = (RL > WL) ? RL : WL;
  localparam int OCCW  = DEPTH + BL;
  localparam logic [BLW-1:0] LASTB = BLW'(BL - 1);

  typedef struct packed {
    logic                      vld;
    logic                      rd;
    logic                      ap;
    logic [RKW-1:0]            rank;
    logic [BGWIDTH-1:0]        bg;
    logic [BAWIDTH-1:0]        ba;
    logic [ADDRWIDTH-1:0]      row;
    logic [COLWIDTH-BLW-1:0]   colhi;
  } burst_t;

  function automatic logic [TBW-1:0] bank_idx(input logic [RKW-1:0] r,
                                              input logic [BGWIDTH-1:0] g,
                                              input logic [BAWIDTH-1:0] b);
    return TBW'(int'(r) * NB + int'(g) * (2 ** BAWIDTH) + int'(b));
  endfunction

  burst_t                 pipe [DEPTH];
  burst_t                 new_ent;
  logic [ADDRWIDTH-1:0]   open_rows [TB];
  logic [OCCW-1:0]        occ, win_new;
  logic [TB-1:0]          close_vec, eff_open, rank_mask, cur_1h, set_vec, clr_vec;
  logic [RKW-1:0]         sel_rank;
  logic [TBW-1:0]         cur_idx, eng_idx;
  int                     n_low, lat;
  logic                   cmd_vld, cmd_multi, par_bad, cmd_ok;
  logic                   is_rd, coll, push, err_nxt, act_set;

  // Beat engine state; beat_* are driven straight from these registers.
  logic                   eng_act, eng_rd, eng_ap;
  logic [BLW-1:0]         eng_cnt;
  logic [COLWIDTH-BLW-1:0] eng_colhi;

  always_comb begin
    n_low    = 0;
    sel_rank = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (!cs_n[r]) begin
        n_low    = n_low + 1;
        sel_rank = RKW'(r);
      end
    end
  end

  assign cmd_vld   = cke && (n_low == 1);
  assign cmd_multi = cke && (n_low > 1);
  assign cur_idx   = bank_idx(sel_rank, bg, ba);
  assign eng_idx   = bank_idx(beat_rank, beat_bg, beat_ba);
  assign is_rd     = (A[16:14] == 3'b101);
  assign lat       = is_rd ? RL : WL;

`ifdef DIMM_CA_PARITY_EN
  logic [2:0] alert_cnt;
  assign par_bad = cmd_vld && (^{act_n, A, bg, ba, parity});
  // Counter reloads on every mismatch so a repeat error stretches the alert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 alert_cnt <= '0;
    else if (par_bad)          alert_cnt <= 3'd4;
    else if (alert_cnt != '0)  alert_cnt <= alert_cnt - 3'd1;
  end
  assign alert_n = (alert_cnt == '0);
`else
  logic unused_parity;
  assign unused_parity = parity;
  assign par_bad       = 1'b0;
  assign alert_n       = 1'b1;
`endif

  assign cmd_ok = cmd_vld && !par_bad;

  always_comb begin
    close_vec = '0;
    rank_mask = '0;
    cur_1h    = '0;
    win_new   = '0;
    set_vec   = '0;
    clr_vec   = '0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    act_set   = 1'b0;
    for (int k = 0; k < TB; k++) begin
      // Auto-precharge closes the bank on the edge after beat_last.
      close_vec[k] = eng_act && eng_ap && (eng_cnt == LASTB) && (k == int'(eng_idx));
      rank_mask[k] = (k / NB) == int'(sel_rank);
      cur_1h[k]    = (k == int'(cur_idx));
    end
    // Close is applied before any same-edge command, so ACT after RDA/WRA close is legal.
    eff_open = row_open & ~close_vec;
    // Beat slots the new burst would occupy, relative to this edge.
    for (int j = 0; j < OCCW; j++) win_new[j] = (j >= lat) && (j < lat + BL);
    coll = |(occ & win_new);

    if (cmd_multi) begin
      err_nxt = 1'b1;
    end else if (cmd_ok) begin
      if (!act_n) begin
        if (|(eff_open & cur_1h)) err_nxt = 1'b1;
        else begin
          set_vec = cur_1h;
          act_set = 1'b1;
        end
      end else begin
        case (A[16:14])
          3'b101, 3'b100: begin
            if (!(|(eff_open & cur_1h)) || coll) err_nxt = 1'b1;
            else                                 push    = 1'b1;
          end
          3'b010:  clr_vec = A[10] ? rank_mask : cur_1h;
          3'b001:  if (|(eff_open & rank_mask)) err_nxt = 1'b1;
          default: ;
        endcase
      end
    end

    new_ent = '{vld: 1'b1, rd: is_rd, ap: A[10], rank: sel_rank, bg: bg, ba: ba,
                row: open_rows[cur_idx], colhi: A[COLWIDTH-1:BLW]};
  end

  always_ff @(posedge clk) begin
    if (act_set) open_rows[cur_idx] <= A;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_open  <= '0;
      cmd_err   <= 1'b0;
      occ       <= '0;
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      eng_act   <= 1'b0;
      eng_rd    <= 1'b0;
      eng_ap    <= 1'b0;
      eng_cnt   <= '0;
      eng_colhi <= '0;
      beat_rank <= '0;
      beat_bg   <= '0;
      beat_ba   <= '0;
      beat_row  <= '0;
    end else begin
      row_open <= (eff_open & ~clr_vec) | set_vec;
      cmd_err  <= err_nxt;
      occ      <= (occ >> 1) | (push ? (win_new >> 1) : '0);
      // Slot 0 is consumed by the beat engine on the next edge; a burst placed
      // in slot lat-1 therefore shows its first beat lat edges after the command.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && i == lat - 1)  pipe[i] <= new_ent;
        else if (i < DEPTH - 1)    pipe[i] <= pipe[i + 1];
        else                       pipe[i] <= '0;
      end
      if (pipe[0].vld) begin
        eng_act   <= 1'b1;
        eng_rd    <= pipe[0].rd;
        eng_ap    <= pipe[0].ap;
        eng_cnt   <= '0;
        eng_colhi <= pipe[0].colhi;
        beat_rank <= pipe[0].rank;
        beat_bg   <= pipe[0].bg;
        beat_ba   <= pipe[0].ba;
        beat_row  <= pipe[0].row;
      end else if (eng_act && eng_cnt != LASTB) begin
        eng_cnt <= eng_cnt + BLW'(1);
      end else begin
        eng_act <= 1'b0;
      end
    end
  end

  // Column low bits are the beat counter itself, so they wrap inside the burst.
  assign beat_col   = {eng_colhi, eng_cnt};
  assign rd_drive   = eng_act && eng_rd;
  assign wr_capture = eng_act && !eng_rd;
  assign beat_last  = eng_act && (eng_cnt == LASTB);

endmodule

// File: tb/tb_dimm_cmd_frontend.sv
module tb_dimm_cmd_frontend;
  localparam int RL = 22, WL = 16, BL = 8, MAXC = 2048;

  logic        clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic [1:0]  cs_n = 2'b11;
  logic        act_n = 1'b1;
  logic [16:0] A = '0;
  logic [1:0]  bg = '0, ba = '0;
  logic        parity = 1'b0;
  logic [31:0] row_open;
  logic        rd_drive, wr_capture, beat_last, cmd_err, alert_n;
  logic [0:0]  beat_rank;
  logic [1:0]  beat_bg, beat_ba;
  logic [16:0] beat_row;
  logic [9:0]  beat_col;

  always #5 clk = ~clk;

  dimm_cmd_frontend dut (
    .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A),
    .bg(bg), .ba(ba), .parity(parity), .row_open(row_open), .rd_drive(rd_drive),
    .wr_capture(wr_capture), .beat_rank(beat_rank), .beat_bg(beat_bg), .beat_ba(beat_ba),
    .beat_row(beat_row), .beat_col(beat_col), .beat_last(beat_last), .cmd_err(cmd_err),
    .alert_n(alert_n)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model: per-cycle expectation tables ----------------
  typedef struct {
    bit v, rd, last;
    int rank, bg, ba, row, col;
  } beat_s;

  beat_s       sched [MAXC];
  bit          err_at [MAXC];
  int          close_at [MAXC];
  logic [31:0] open_m;
  int          row_m [32];
  int          alert_until;
  beat_s       hold, cur;

  task automatic clear_model();
    open_m      = '0;
    alert_until = -1;
    hold        = '{default: 0};
    for (int i = 0; i < MAXC; i++) begin
      sched[i]    = '{default: 0};
      err_at[i]   = 1'b0;
      close_at[i] = -1;
    end
  endtask

  task automatic step();
    int nlow, rk, idx, lat;
    bit coll, any;
    nlow = 0; rk = 0;
    for (int r = 0; r < 2; r++) if (!cs_n[r]) begin nlow++; rk = r; end
    if (close_at[cyc] >= 0) open_m[close_at[cyc]] = 1'b0;
    if (!cke || nlow == 0) return;
    if (nlow > 1) begin err_at[cyc] = 1'b1; return; end
`ifdef DIMM_CA_PARITY_EN
    if ((^{act_n, A, bg, ba}) != parity) begin alert_until = cyc + 3; return; end
`endif
    idx = rk * 16 + int'(bg) * 4 + int'(ba);
    if (!act_n) begin
      if (open_m[idx]) err_at[cyc] = 1'b1;
      else begin open_m[idx] = 1'b1; row_m[idx] = int'(A); end
      return;
    end
    case (A[16:14])
      3'b101, 3'b100: begin
        lat  = (A[16:14] == 3'b101) ? RL : WL;
        coll = 1'b0;
        for (int k = 0; k < BL; k++) if (sched[cyc + lat + k].v) coll = 1'b1;
        if (!open_m[idx] || coll) err_at[cyc] = 1'b1;
        else begin
          for (int k = 0; k < BL; k++)
            sched[cyc + lat + k] = '{v: 1'b1, rd: (lat == RL), last: (k == BL - 1),
                                     rank: rk, bg: int'(bg), ba: int'(ba), row: row_m[idx],
                                     col: (int'(A[9:0]) / BL) * BL + k};
          if (A[10]) close_at[cyc + lat + BL] = idx;
        end
      end
      3'b010: begin
        if (A[10]) for (int b = 0; b < 16; b++) open_m[rk * 16 + b] = 1'b0;
        else open_m[idx] = 1'b0;
      end
      3'b001: begin
        any = 1'b0;
        for (int b = 0; b < 16; b++) if (open_m[rk * 16 + b]) any = 1'b1;
        if (any) err_at[cyc] = 1'b1;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && cyc + 64 < MAXC) step();
  end

  always @(posedge reset) clear_model();

  // One compare process checks every output on every cycle out of reset.
  always @(negedge clk) begin
    if (!reset && cyc > 0 && cyc < MAXC) begin
      cur = sched[cyc];
      if (cur.v) hold = cur;
      chk("row_open",   row_open,   open_m);
      chk("rd_drive",   rd_drive,   cur.v && cur.rd);
      chk("wr_capture", wr_capture, cur.v && !cur.rd);
      chk("beat_last",  beat_last,  cur.v && cur.last);
      chk("beat_rank",  beat_rank,  hold.rank);
      chk("beat_bg",    beat_bg,    hold.bg);
      chk("beat_ba",    beat_ba,    hold.ba);
      chk("beat_row",   beat_row,   hold.row);
      chk("beat_col",   beat_col,   hold.col);
      chk("cmd_err",    cmd_err,    err_at[cyc]);
      chk("alert_n",    alert_n,    !(cyc <= alert_until));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [1:0] cs_of(input int r);
    return (r == 0) ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [16:0] a_rd(input logic [9:0] col, input bit ap);
    return 17'h14000 | (ap ? 17'h00400 : 17'h0) | {7'd0, col};
  endfunction
  function automatic logic [16:0] a_wr(input logic [9:0] col, input bit ap);
    return 17'h10000 | (ap ? 17'h00400 : 17'h0) | {7'd0, col};
  endfunction
  function automatic logic [16:0] a_pre(input bit all);
    return 17'h08000 | (all ? 17'h00400 : 17'h0);
  endfunction

  task automatic issue(input logic [1:0] csn, input logic actn, input logic [16:0] a,
                       input logic [1:0] g, input logic [1:0] b, input bit badpar);
    cs_n = csn; act_n = actn; A = a; bg = g; ba = b;
    parity = (^{actn, a, g, b}) ^ badpar;
    @(negedge clk);
    cs_n = 2'b11; act_n = 1'b1; A = '0; bg = '0; ba = '0; parity = 1'b0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 4000 && cyc < c; i++) @(negedge clk);
  endtask

  initial begin
    int c, c1, n;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_row_open",  row_open,   32'h0);
    chk("rst_rd_drive",  rd_drive,   1'b0);
    chk("rst_wr_cap",    wr_capture, 1'b0);
    chk("rst_beat_col",  beat_col,   10'h0);
    chk("rst_beat_row",  beat_row,   17'h0);
    chk("rst_beat_last", beat_last,  1'b0);
    chk("rst_cmd_err",   cmd_err,    1'b0);
    chk("rst_alert_n",   alert_n,    1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ACT r1 bg2 ba1 then RD col 0x045
    issue(cs_of(1), 1'b0, 17'h1ABC, 2'd2, 2'd1, 1'b0);
    repeat (2) @(negedge clk);
    issue(cs_of(1), 1'b1, a_rd(10'h045, 1'b0), 2'd2, 2'd1, 1'b0);
    c = cyc;
    chk("act_open25", row_open[25], 1'b1);
    wait_until(c + 21); chk("rd_before", rd_drive, 1'b0);
    wait_until(c + 22);
    chk("rd_first",    rd_drive,  1'b1);
    chk("rd_col0",     beat_col,  10'h040);
    chk("rd_row",      beat_row,  17'h1ABC);
    chk("rd_rank",     beat_rank, 1'b1);
    chk("rd_bg",       beat_bg,   2'd2);
    chk("rd_ba",       beat_ba,   2'd1);
    wait_until(c + 29);
    chk("rd_col7",     beat_col,  10'h047);
    chk("rd_last",     beat_last, 1'b1);
    wait_until(c + 30);
    chk("rd_end",      rd_drive,  1'b0);
    chk("rd_col_hold", beat_col,  10'h047);

    // WRA col 0x3FF on r0 bg0 ba0
    issue(cs_of(0), 1'b0, 17'h0055, 2'd0, 2'd0, 1'b0);
    issue(cs_of(0), 1'b1, a_wr(10'h3FF, 1'b1), 2'd0, 2'd0, 1'b0);
    c = cyc;
    wait_until(c + 15); chk("wr_before", wr_capture, 1'b0);
    wait_until(c + 16); chk("wr_first", wr_capture, 1'b1); chk("wr_col0", beat_col, 10'h3F8);
    wait_until(c + 23); chk("wr_col7", beat_col, 10'h3FF); chk("wr_last", beat_last, 1'b1);
    chk("wra_open", row_open[0], 1'b1);
    wait_until(c + 24); chk("wra_closed", row_open[0], 1'b0); chk("wr_end", wr_capture, 1'b0);

    // Illegal commands: RD closed bank, ACT open bank, two chip selects
    issue(cs_of(0), 1'b1, a_rd(10'h000, 1'b0), 2'd0, 2'd0, 1'b0);
    chk("err_rd_closed", cmd_err, 1'b1);
    @(negedge clk); chk("err_pulse_end", cmd_err, 1'b0);
    issue(cs_of(1), 1'b0, 17'h0123, 2'd2, 2'd1, 1'b0);
    chk("err_act_open", cmd_err, 1'b1);
    chk("err_act_rows", row_open, 32'h0200_0000);
    @(negedge clk);
    issue(2'b00, 1'b0, 17'h0042, 2'd3, 2'd3, 1'b0);
    chk("err_multi_cs", cmd_err, 1'b1);
    chk("err_multi_rows", row_open, 32'h0200_0000);
    c = cyc; n = 0;
    for (int i = 1; i <= 30; i++) begin wait_until(c + i); if (rd_drive || wr_capture) n++; end
    chk("err_no_beats", n, 0);

    // Gapless pair, then a colliding third RD
    issue(cs_of(1), 1'b1, a_rd(10'h010, 1'b0), 2'd2, 2'd1, 1'b0);
    c1 = cyc;
    wait_until(c1 + 7);
    issue(cs_of(1), 1'b1, a_rd(10'h020, 1'b0), 2'd2, 2'd1, 1'b0);
    wait_until(c1 + 11);
    issue(cs_of(1), 1'b1, a_rd(10'h030, 1'b0), 2'd2, 2'd1, 1'b0);
    chk("err_collide", cmd_err, 1'b1);
    n = 0;
    for (int i = 22; i <= 37; i++) begin wait_until(c1 + i); if (rd_drive) n++; end
    chk("gapless_16", n, 16);
    wait_until(c1 + 38); chk("gapless_end", rd_drive, 1'b0);

    // PREA, REF legal/illegal, PRE single
    issue(cs_of(1), 1'b1, a_pre(1'b1), 2'd0, 2'd0, 1'b0);
    chk("prea_rows", row_open, 32'h0);
    issue(cs_of(1), 1'b1, 17'h04000, 2'd0, 2'd0, 1'b0);
    chk("ref_ok", cmd_err, 1'b0);
    issue(cs_of(0), 1'b0, 17'h0005, 2'd3, 2'd2, 1'b0);
    issue(cs_of(0), 1'b1, 17'h04000, 2'd0, 2'd0, 1'b0);
    chk("ref_open_err", cmd_err, 1'b1);
    issue(cs_of(0), 1'b1, a_pre(1'b0), 2'd3, 2'd2, 1'b0);
    chk("pre_rows", row_open, 32'h0);

    // RDA close coinciding with a new ACT to the same bank
    issue(cs_of(0), 1'b0, 17'h0AAA, 2'd1, 2'd3, 1'b0);
    issue(cs_of(0), 1'b1, a_rd(10'h000, 1'b1), 2'd1, 2'd3, 1'b0);
    c = cyc;
    wait_until(c + 29);
    issue(cs_of(0), 1'b0, 17'h0777, 2'd1, 2'd3, 1'b0);
    chk("reopen_err", cmd_err, 1'b0);
    chk("reopen_bit", row_open[7], 1'b1);
    issue(cs_of(0), 1'b1, a_rd(10'h008, 1'b0), 2'd1, 2'd3, 1'b0);
    c = cyc;
    wait_until(c + 22); chk("reopen_row", beat_row, 17'h0777); chk("reopen_col", beat_col, 10'h008);
    wait_until(c + 31);

    // Reset during the third read beat
    issue(cs_of(0), 1'b1, a_rd(10'h000, 1'b0), 2'd1, 2'd3, 1'b0);
    c = cyc;
    wait_until(c + 24); chk("mid_burst", rd_drive, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_kill_rd", rd_drive, 1'b0);
    chk("rst_kill_rows", row_open, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c = cyc; n = 0;
    for (int i = 1; i <= 40; i++) begin wait_until(c + i); if (rd_drive || wr_capture) n++; end
    chk("rst_no_beats", n, 0);

`ifdef DIMM_CA_PARITY_EN
    issue(cs_of(0), 1'b0, 17'h0321, 2'd2, 2'd2, 1'b1);
    c = cyc;
    chk("par_alert", alert_n, 1'b0);
    chk("par_no_err", cmd_err, 1'b0);
    chk("par_rows", row_open, 32'h0);
    wait_until(c + 3); chk("par_alert_4th", alert_n, 1'b0);
    wait_until(c + 4); chk("par_alert_end", alert_n, 1'b1);
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
